// File: rtl/pattern_seq_detector.sv
// rtl/pattern_seq_detector.sv - serial pattern detector with loadable pattern, overlap mode and saturating match counter
module pattern_seq_detector #(
  parameter int              PLEN    = 2,
  parameter logic [PLEN-1:0] PAT_RST = 2'b01,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             A,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PLEN-1:0]  pat_in,
  input  logic             cnt_clr,
  output logic             Y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FILL_W  = $clog2(PLEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PLEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [PLEN-1:0]   pat_q, pat_d;
  logic [PLEN-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              y_q, y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PLEN-1:0]   h_nx;
  logic [FILL_W-1:0] f_nx;
  logic              hit;
  logic [CNT_W-1:0]  cnt_base;

  // Candidate history and fill level if this edge samples A.
  always_comb begin
    h_nx = {hist_q[PLEN-2:0], A};
    f_nx = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    hit  = en && !pat_load && (f_nx == FILL_MAX) && (h_nx == pat_q);
  end

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      y_d    = hit;
      hist_d = h_nx;
      fill_d = (hit && !overlap) ? '0 : f_nx;
    end
  end

  // Clear takes effect before the increment so a coincident match still counts.
  always_comb begin
    cnt_base = cnt_clr ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (hit && (cnt_base != CNT_MAX)) begin
      cnt_d = cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Y         = y_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_pattern_seq_detector.sv
// tb/tb_pattern_seq_detector.sv - scoreboard bench for pattern_seq_detector against a bit-window reference model
module tb_pattern_seq_detector;

  localparam int              PLEN    = 4;
  localparam logic [PLEN-1:0] PAT_RST = 4'b0110;
  localparam int              CNT_W   = 3;
  localparam int              CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, en, A, overlap, pat_load, cnt_clr;
  logic [PLEN-1:0]  pat_in;
  logic             Y, cnt_sat;
  logic [CNT_W-1:0] match_cnt;

  always #5 clk = ~clk;

  pattern_seq_detector #(.PLEN(PLEN), .PAT_RST(PAT_RST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .A(A), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .Y(Y), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  typedef struct {
    logic             y;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    int               id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int step_id = 0;

  // Reference: bits received since the last reset/load/non-overlap restart, oldest first.
  logic [PLEN-1:0] pat_m;
  bit              win[$];
  int              cnt_m;

  task automatic step(input logic r, input logic e, input logic a, input logic ov,
                      input logic ld, input logic [PLEN-1:0] pin, input logic clr);
    exp_t x;
    bit   hit;
    @(negedge clk);
    rst = r; en = e; A = a; overlap = ov; pat_load = ld; pat_in = pin; cnt_clr = clr;
    hit = 0;
    if (r) begin
      pat_m = PAT_RST;
      win.delete();
      cnt_m = 0;
    end else begin
      if (ld) begin
        pat_m = pin;
        win.delete();
      end else if (e) begin
        win.push_back(a);
        if (win.size() > PLEN) void'(win.pop_front());
        if (win.size() == PLEN) begin
          hit = 1;
          for (int i = 0; i < PLEN; i++)
            if (win[i] != pat_m[PLEN-1-i]) hit = 0;
        end
        if (hit && !ov) win.delete();
      end
      if (clr) cnt_m = 0;
      if (hit && cnt_m < CMAX) cnt_m++;
    end
    step_id++;
    x.y   = hit;
    x.cnt = CNT_W'(cnt_m);
    x.sat = (cnt_m == CMAX);
    x.id  = step_id;
    sb.push_back(x);
  endtask

  task automatic bits(input logic [15:0] seq, input int n, input logic ov);
    logic [15:0] s;
    s = seq;
    for (int i = n - 1; i >= 0; i--) step(0, 1, s[i], ov, 0, '0, 0);
  endtask

  task automatic load(input logic [PLEN-1:0] p, input logic e, input logic a);
    step(0, e, a, 1, 1, p, 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (Y !== x.y || match_cnt !== x.cnt || cnt_sat !== x.sat) begin
          errors++;
          $display("FAIL step%0d got Y=%b cnt=%0d sat=%b expected Y=%b cnt=%0d sat=%b",
                   x.id, Y, match_cnt, cnt_sat, x.y, x.cnt, x.sat);
        end
      end
    end
  end

  initial begin : driver
    rst = 1; en = 0; A = 0; overlap = 1; pat_load = 0; pat_in = '0; cnt_clr = 0;
    pat_m = PAT_RST; cnt_m = 0;
    step(1, 0, 0, 1, 0, '0, 0);
    step(1, 1, 1, 1, 1, 4'hF, 1);

    // Overlapping then non-overlapping detection of 1010.
    load(4'b1010, 0, 0);
    bits(16'b101010, 6, 1);
    load(4'b1010, 0, 0);
    bits(16'b101010, 6, 0);

    // Gaps in en keep the partial match.
    load(4'b1010, 0, 0);
    step(0, 1, 1, 1, 0, '0, 0);
    repeat (3) step(0, 0, 0, 1, 0, '0, 0);
    bits(16'b010, 3, 1);

    // Saturation, then clear coincident with a hit.
    step(0, 0, 0, 1, 0, '0, 1);
    load(4'b1111, 0, 0);
    bits(16'hFFFF, 12, 1);
    step(0, 1, 1, 1, 0, '0, 1);
    step(0, 1, 1, 1, 0, '0, 0);

    // Reset after three matching bits of the reset pattern.
    step(1, 0, 0, 1, 0, '0, 0);
    bits(16'b011, 3, 1);
    step(1, 1, 0, 1, 0, '0, 0);
    bits(16'b0, 1, 1);
    bits(16'b0110, 4, 1);

    // Load mid-pattern with en=1; A on the load edge is ignored.
    load(4'b1010, 0, 0);
    bits(16'b101, 3, 1);
    load(4'b0011, 1, 0);
    bits(16'b0011, 4, 1);
    load(4'b0011, 0, 0);
    bits(16'b011, 3, 1);

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80), 1'($urandom),
           ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3),
           PLEN'($urandom), ($urandom_range(0, 99) < 4));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
